hdmi_video_timing: RTL
======================

// Module: hdmi_video_timing
// PURPOSE
//  Free-running HDMI raster timing generator fed by video_analyzer's mode/vreset outputs.
//  Produces hs/vs/de and pixel coordinates for the HDMI encoder.
//  On a vreset pulse it snaps its counters to the first visible pixel, re-aligning the HDMI raster to the source frame.
//  Tracks lock state. Applies mode changes only at frame boundaries.
// PARAMETERS
//  H_RESYNC  0  hcnt loaded on vreset
//  V_RESYNC  0  vcnt loaded on vreset
// PORTS
//  clk          in   1   system clock, the only clock
//  reset        in   1   asynchronous, active-high reset
//  ce           in   1   pixel clock enable; counters advance only when ce=1
//  mode         in   2   0=ntsc, 1=pal, 2=mono, 3=treated as mono
//  vreset       in   1   single-cycle resync request (any ce phase)
//  hs           out  1   hsync, active-low
//  vs           out  1   vsync, active-low
//  de           out  1   data enable, high in active area
//  hcnt         out  12  current pixel x
//  vcnt         out  11  current line y
//  sof          out  1   start-of-frame strobe, one clk, at (0,0) with ce
//  locked       out  1   raster aligned to source since last mode change
//  mode_active  out  2   mode currently being generated
// BEHAVIOUR
//  Reset: hcnt=0, vcnt=0, hs=1, vs=1, de=0, sof=0, locked=0, mode_active=1 (pal), pending=0.
//  Timing table (htot/hact/hfp/hsw ; vtot/vact/vfp/vsw):
//   ntsc 858/720/16/62 ; 525/480/9/6
//   pal  864/720/12/64 ; 625/576/5/5
//   mono 800/640/16/96 ; 525/480/10/2
//  Counting, on clk with ce=1:
//   hcnt++; at htot-1 it wraps to 0 and vcnt++; at vtot-1 vcnt wraps to 0.
//  Outputs are registered from the pre-increment counter values: 1 clk latency, updated only on ce cycles.
//   de = hcnt<hact && vcnt<vact.
//   hs = 0 for hact+hfp <= hcnt < hact+hfp+hsw.
//   vs = 0 for vact+vfp <= vcnt < vact+vfp+vsw (whole lines).
//  vreset:
//   - Sets pending.
//   - On the next ce cycle (same cycle if ce=1): hcnt<=H_RESYNC, vcnt<=V_RESYNC, pending cleared, FSM->LOCKED.
//   - A vreset arriving while pending is already set is merged (no double apply).
//  Mode:
//   - mode is sampled every clk into mode_req.
//   - When mode_req != mode_active, it is applied at the wrap to (0,0): mode_active<=mode_req, FSM->SEARCH.
//   - hcnt/vcnt beyond the new totals cannot occur because the change happens only at (0,0).
//  FSM, two states:
//   SEARCH: locked=0. Free-runs in mode_active. Goes to LOCKED on an applied vreset.
//   LOCKED: locked=1. Goes to SEARCH on an applied mode change.
//  Simultaneous mode change and vreset on the same frame-wrap ce cycle:
//   the new mode is latched AND the counters load the resync values; FSM ends in LOCKED.
//  sof is asserted only for a natural wrap to (0,0), not for a resync load.
//  Async reset mid-frame returns every register to its reset value immediately; counting restarts at (0,0) in PAL, SEARCH.
//  Widths: counters unsigned; compares zero-extended; no arithmetic overflow possible (max 864 < 2^12).
// STRUCTURE
//  Shared package video_timing_pkg:
//   - mode encodings MODE_NTSC/MODE_PAL/MODE_MONO
//   - struct timing_t {htot,hact,hfp,hsw,vtot,vact,vfp,vsw}
//   - per-mode constants
//  One sub-module: video_mode_table (combinational mode -> timing_t lookup).
//  FSM, counters and sync generation stay in this file.
// TESTING
//  1 Reset, mode=1, ce=1 constantly:
//    de high for 720 clks per line; hs low for clk hcnt 732..795; frame period 864*625 = 540000 clks; sof once per frame; locked=0.
//  2 mode=0 mid-frame:
//    mode_active stays 1 until the (0,0) wrap, then 0; next frame measures 858*525; locked drops at that wrap.
//  3 vreset pulse at arbitrary (hcnt=300, vcnt=200), ce=1:
//    next clk hcnt=0, vcnt=0, locked=1; no sof strobe for this load.
//  4 ce toggling 1-of-4, vreset on a ce=0 cycle:
//    counters hold until the next ce; load applied there; vreset repeated while pending -> loaded exactly once.
//  5 Mode change and vreset coinciding with the frame wrap:
//    mode_active updated, counters (0,0), locked=1.
//  6 Assert reset in the middle of the active area:
//    all outputs take their reset values in the same clk; after release counting restarts at (0,0) in PAL.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared mode encodings, raster timing record and per-mode timing constants
// for the HDMI video timing generator.
package video_timing_pkg;

    localparam logic [1:0] MODE_NTSC = 2'd0;
    localparam logic [1:0] MODE_PAL  = 2'd1;
    localparam logic [1:0] MODE_MONO = 2'd2;

    typedef struct packed {
        logic [11:0] htot;
        logic [11:0] hact;
        logic [11:0] hfp;
        logic [11:0] hsw;
        logic [10:0] vtot;
        logic [10:0] vact;
        logic [10:0] vfp;
        logic [10:0] vsw;
    } timing_t;

    localparam timing_t TIMING_NTSC = '{
        htot: 12'd858, hact: 12'd720, hfp: 12'd16, hsw: 12'd62,
        vtot: 11'd525, vact: 11'd480, vfp: 11'd9,  vsw: 11'd6
    };

    localparam timing_t TIMING_PAL = '{
        htot: 12'd864, hact: 12'd720, hfp: 12'd12, hsw: 12'd64,
        vtot: 11'd625, vact: 11'd576, vfp: 11'd5,  vsw: 11'd5
    };

    localparam timing_t TIMING_MONO = '{
        htot: 12'd800, hact: 12'd640, hfp: 12'd16, hsw: 12'd96,
        vtot: 11'd525, vact: 11'd480, vfp: 11'd10, vsw: 11'd2
    };

    typedef enum logic {StSearch, StLocked} sync_state_e;

endpackage

// File: rtl/video_mode_table.sv
// Combinational lookup from a video mode code to its raster timing record.
module video_mode_table
    import video_timing_pkg::*;
(
    input  logic [1:0] mode,
    output timing_t    timing
);

    // Code 3 is not a distinct standard; it falls through to mono.
    always_comb begin
        timing = TIMING_MONO;
        case (mode)
            MODE_NTSC: timing = TIMING_NTSC;
            MODE_PAL:  timing = TIMING_PAL;
            default:   timing = TIMING_MONO;
        endcase
    end

endmodule

// File: rtl/hdmi_video_timing.sv
// Free-running HDMI raster generator: counters, sync/de generation, vreset
// re-alignment, frame-boundary mode switching and lock tracking.
module hdmi_video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned H_RESYNC = 0,
    parameter int unsigned V_RESYNC = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [1:0]  mode,
    input  logic        vreset,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [11:0] hcnt,
    output logic [10:0] vcnt,
    output logic        sof,
    output logic        locked,
    output logic [1:0]  mode_active
);

    timing_t     tm;
    sync_state_e state_q, state_d;
    logic [11:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, sof_q, sof_d;
    logic        pending_q, pending_d;
    logic [1:0]  mode_req_q, mode_req_d, mode_active_q, mode_active_d;
    logic [11:0] hs_start, hs_stop;
    logic [10:0] vs_start, vs_stop;
    logic        h_end, v_end, frame_end, resync, mode_change;

    video_mode_table u_mode_table (
        .mode   (mode_active_q),
        .timing (tm)
    );

    assign h_end       = (hcnt_q == tm.htot - 12'd1);
    assign v_end       = (vcnt_q == tm.vtot - 11'd1);
    assign frame_end   = h_end && v_end;
    assign resync      = ce && (pending_q || vreset);
    assign mode_change = ce && frame_end && (mode_req_q != mode_active_q);
    assign hs_start    = tm.hact + tm.hfp;
    assign hs_stop     = hs_start + tm.hsw;
    assign vs_start    = tm.vact + tm.vfp;
    assign vs_stop     = vs_start + tm.vsw;

    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        de_d          = de_q;
        sof_d         = 1'b0;
        state_d       = state_q;
        mode_active_d = mode_active_q;
        pending_d     = (pending_q || vreset) && !ce;
        mode_req_d    = (mode == 2'd3) ? MODE_MONO : mode;

        if (ce) begin
            // Sync/de reflect the position being left, hence one ce of latency.
            de_d = (hcnt_q < tm.hact) && (vcnt_q < tm.vact);
            hs_d = !((hcnt_q >= hs_start) && (hcnt_q < hs_stop));
            vs_d = !((vcnt_q >= vs_start) && (vcnt_q < vs_stop));

            if (resync) begin
                hcnt_d = 12'(H_RESYNC);
                vcnt_d = 11'(V_RESYNC);
            end else if (h_end) begin
                hcnt_d = 12'd0;
                vcnt_d = v_end ? 11'd0 : vcnt_q + 11'd1;
                sof_d  = v_end;
            end else begin
                hcnt_d = hcnt_q + 12'd1;
            end
        end

        if (mode_change) begin
            mode_active_d = mode_req_q;
        end

        // A resync on the same cycle as a mode change still leaves us aligned.
        if (resync) begin
            state_d = StLocked;
        end else if (mode_change) begin
            state_d = StSearch;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q        <= 12'd0;
            vcnt_q        <= 11'd0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            de_q          <= 1'b0;
            sof_q         <= 1'b0;
            pending_q     <= 1'b0;
            mode_req_q    <= MODE_PAL;
            mode_active_q <= MODE_PAL;
            state_q       <= StSearch;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            sof_q         <= sof_d;
            pending_q     <= pending_d;
            mode_req_q    <= mode_req_d;
            mode_active_q <= mode_active_d;
            state_q       <= state_d;
        end
    end

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign sof         = sof_q;
    assign mode_active = mode_active_q;
    assign locked      = (state_q == StLocked);

endmodule
